// File: rtl/alu_seq.sv
// alu_seq: sequential ALU for the EX stage.
// Single-cycle ops finish on the start edge. MUL and DIV iterate one bit per
// clock on a shared 2*WIDTH accumulator. Every operation ends with a one-cycle
// done pulse, and the results and flags are held until the next done.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [3:0]       alu_op,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result2,
    output logic             equal,
    output logic             ovf,
    output logic             div0
);

    localparam logic [3:0] OP_SLL  = 4'b0000;
    localparam logic [3:0] OP_SRA  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_DIV  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_SLT  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t state, state_next;

    // Accumulator layout: MUL keeps {partial product high, remaining multiplier};
    // DIV keeps {partial remainder, dividend bits shifting into quotient bits}.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opx;
    logic [WIDTH-1:0]   opy;
    logic [SHW-1:0]     cnt;
    logic               last_iter;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   sc_result;
    logic               sc_ovf;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ok;
    logic [WIDTH-1:0]   div_rem;

    assign last_iter = (cnt == SHW'(WIDTH - 1));

    // Single-cycle result and overflow, computed straight from the live inputs
    // because they are registered on the same edge that samples start.
    always_comb begin
        sum       = x + y;
        diff      = x - y;
        sc_result = '0;
        sc_ovf    = 1'b0;
        case (alu_op)
            OP_SLL:  sc_result = y << shamt;
            OP_SRA:  sc_result = $signed(y) >>> shamt;
            OP_SRL:  sc_result = y >> shamt;
            OP_ADD: begin
                sc_result = sum;
                sc_ovf    = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = diff;
                sc_ovf    = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
            end
            OP_AND:  sc_result = x & y;
            OP_OR:   sc_result = x | y;
            OP_XOR:  sc_result = x ^ y;
            OP_NOR:  sc_result = ~(x | y);
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (x < y)};
            default: sc_result = '0;
        endcase
    end

    // One iteration step: shift-add for MUL, and a restoring step for DIV that
    // produces one quotient bit MSB first. A zero divisor always "fits", which
    // gives an all-ones quotient and leaves the dividend as the remainder.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opx : {WIDTH{1'b0}})};
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, opy});
        div_diff  = div_shift[WIDTH-1:0] - opy;
        div_rem   = div_ok ? div_diff : div_shift[WIDTH-1:0];
        acc_step  = acc;
        case (state)
            S_MUL:   acc_step = {mul_sum, acc[WIDTH-1:1]};
            S_DIV:   acc_step = {div_rem, acc[WIDTH-2:0], div_ok};
            default: acc_step = acc;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: only MUL/DIV leave IDLE, and they return after WIDTH steps.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start && (alu_op == OP_MUL)) begin
                    state_next = S_MUL;
                end else if (start && (alu_op == OP_DIV)) begin
                    state_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (last_iter) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs. start is sampled only in IDLE, so a
    // request while busy is dropped, and the latched operands keep the
    // iteration independent of later input changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            opx     <= '0;
            opy     <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            result2 <= '0;
            equal   <= 1'b0;
            ovf     <= 1'b0;
            div0    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        opx <= x;
                        opy <= y;
                        cnt <= '0;
                        if (alu_op == OP_MUL) begin
                            acc  <= {{WIDTH{1'b0}}, y};
                            busy <= 1'b1;
                        end else if (alu_op == OP_DIV) begin
                            acc  <= {{WIDTH{1'b0}}, x};
                            busy <= 1'b1;
                        end else begin
                            result  <= sc_result;
                            result2 <= '0;
                            equal   <= (x == y);
                            ovf     <= sc_ovf;
                            div0    <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    acc <= acc_step;
                    cnt <= cnt + SHW'(1);
                    if (last_iter) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= acc_step[WIDTH-1:0];
                        result2 <= acc_step[2*WIDTH-1:WIDTH];
                        equal   <= (opx == opy);
                        ovf     <= 1'b0;
                        div0    <= (state == S_DIV) && (opy == '0);
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
